axi_rd_arbiter: RTL and testbench

//  Shares the single AXI read-address/read-data channel pair between the IF-stage fetch port and the EX-stage load port.

---
 rtl/axi_rd_arbiter_pkg.sv | 26 ++
 rtl/rd_outst_cnt.sv | 34 +++
 rtl/axi_rd_arbiter.sv | 154 +++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read-channel arbiter: read IDs, FSM and grant encodings.
package axi_rd_arbiter_pkg;

    localparam int         AXI_ID_W    = 4;
    localparam logic [3:0] AXI_ID_INST = 4'd0;
    localparam logic [3:0] AXI_ID_DATA = 4'd1;
    localparam int         CNT_W       = 2;

    // AR channel FSM: IDLE arbitrates, AR_BUSY holds the address until arready
    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_BUSY = 1'b1
    } ar_state_e;

    // Last winner of arbitration, used to alternate on ties
    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } grant_e;

    // Two byte addresses fall in the same 32-bit word
    function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

endpackage

// File: rtl/rd_outst_cnt.sv
// Saturating outstanding-read counter for one AXI read ID.
// A simultaneous inc and dec leaves the count unchanged; it never wraps.
module rd_outst_cnt
    import axi_rd_arbiter_pkg::*;
#(
    parameter int MAX = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    logic [CNT_W-1:0] cnt_reg;

    // Count issued reads up and returned reads down, clamped at both ends
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else if (inc && !dec && !full) begin
            cnt_reg <= cnt_reg + 1'b1;
        end else if (dec && !inc && !empty) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign full  = (cnt_reg >= MAX_C);
    assign empty = (cnt_reg == '0);

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI AR/R channel pair between the fetch port
// and the load port, with per-ID outstanding limits, rid-based response routing
// and a read-after-write hold on loads that hit the word of an in-flight store.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int         MAX_OUTST = 2,
    parameter logic [3:0] INST_ID   = AXI_ID_INST,
    parameter logic [3:0] DATA_ID   = AXI_ID_DATA
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    input  logic        wr_pend,
    input  logic [31:0] wr_pend_addr,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready
);

    // Index 0 tracks fetch reads, index 1 tracks load reads
    localparam int N_PORT = 2;

    ar_state_e    state_reg, state_next;
    grant_e       last_grant_reg;
    logic [3:0]   arid_reg;
    logic [31:0]  araddr_reg;
    logic [2:0]   arsize_reg;
    logic         arvalid_reg;

    logic         inst_elig, data_elig;
    logic         grant_inst, grant_data;
    logic         raw_hazard;
    logic         resp_fire;

    logic [N_PORT-1:0] cnt_inc, cnt_dec, cnt_full, cnt_empty;

    // Outstanding counters, one per read ID
    genvar gi;
    generate
        for (gi = 0; gi < N_PORT; gi++) begin : g_cnt
            rd_outst_cnt #(
                .MAX (MAX_OUTST)
            ) u_cnt (
                .clk   (aclk),
                .srst  (reset),
                .inc   (cnt_inc[gi]),
                .dec   (cnt_dec[gi]),
                .full  (cnt_full[gi]),
                .empty (cnt_empty[gi])
            );
        end
    endgenerate

    // A load to the same word as a pending store must wait for the store
    assign raw_hazard = wr_pend && same_word(wr_pend_addr, data_addr);
    assign inst_elig  = inst_req && !cnt_full[0];
    assign data_elig  = data_req && !cnt_full[1] && !raw_hazard;

    // Next-state and grant decision; grants only in IDLE and never during reset
    always_comb begin
        state_next = state_reg;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        case (state_reg)
            AR_IDLE: begin
                if (!reset) begin
                    grant_inst = inst_elig && (!data_elig || (last_grant_reg == GNT_DATA));
                    grant_data = data_elig && (!inst_elig || (last_grant_reg == GNT_INST));
                    if (grant_inst || grant_data) begin
                        state_next = AR_BUSY;
                    end
                end
            end
            AR_BUSY: begin
                if (arready) begin
                    state_next = AR_IDLE;
                end
            end
            default: state_next = AR_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge aclk) begin
        if (reset) begin
            state_reg <= AR_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // AR register: latch the winner's request, hold it until the slave takes it
    always_ff @(posedge aclk) begin
        if (reset) begin
            arid_reg       <= '0;
            araddr_reg     <= '0;
            arsize_reg     <= '0;
            arvalid_reg    <= 1'b0;
            last_grant_reg <= GNT_INST;
        end else if (grant_inst) begin
            arid_reg       <= INST_ID;
            araddr_reg     <= inst_addr;
            arsize_reg     <= {1'b0, inst_size};
            arvalid_reg    <= 1'b1;
            last_grant_reg <= GNT_INST;
        end else if (grant_data) begin
            arid_reg       <= DATA_ID;
            araddr_reg     <= data_addr;
            arsize_reg     <= {1'b0, data_size};
            arvalid_reg    <= 1'b1;
            last_grant_reg <= GNT_DATA;
        end else if ((state_reg == AR_BUSY) && arready) begin
            arvalid_reg    <= 1'b0;
        end
    end

    assign arid    = arid_reg;
    assign araddr  = araddr_reg;
    assign arsize  = arsize_reg;
    assign arvalid = arvalid_reg;

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    // R channel is always accepted outside reset; stray responses are dropped
    assign rready       = !reset;
    assign resp_fire    = rvalid && rready;
    assign inst_data_ok = resp_fire && (rid == INST_ID) && !cnt_empty[0];
    assign data_data_ok = resp_fire && (rid == DATA_ID) && !cnt_empty[1];
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign cnt_inc = {grant_data, grant_inst};
    assign cnt_dec = {data_data_ok, inst_data_ok};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: AR issues and R returns are checked
// against scoreboard queues filled as stimulus is driven.
module tb_axi_rd_arbiter;

    logic        aclk = 1'b0;
    logic        reset;
    logic        inst_req, data_req, wr_pend, arready, rvalid;
    logic [31:0] inst_addr, data_addr, wr_pend_addr, rdata;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  rid;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata, araddr;
    logic [3:0]  arid;
    logic [2:0]  arsize;
    logic        arvalid, rready;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [2:0]  size;
    } ar_exp_t;

    ar_exp_t     ar_q[$];
    logic [31:0] inst_q[$];
    logic [31:0] data_q[$];
    ar_exp_t     mon_ar;
    logic [31:0] mon_d;

    always #5 aclk = ~aclk;

    axi_rd_arbiter dut (
        .aclk         (aclk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_size    (inst_size),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_addr    (data_addr),
        .data_size    (data_size),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .wr_pend      (wr_pend),
        .wr_pend_addr (wr_pend_addr),
        .arid         (arid),
        .araddr       (araddr),
        .arsize       (arsize),
        .arvalid      (arvalid),
        .arready      (arready),
        .rid          (rid),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .rready       (rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point)
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Advance to the falling edge (output sample point)
    task automatic probe();
        @(negedge aclk);
    endtask

    // One R beat; expect_ok says whether the arbiter should route it
    task automatic respond(input logic [3:0] id, input logic [31:0] d, input bit expect_ok);
        rvalid = 1'b1;
        rid    = id;
        rdata  = d;
        if (expect_ok && id == 4'd0) inst_q.push_back(d);
        if (expect_ok && id == 4'd1) data_q.push_back(d);
        probe();
        chk("resp_inst_data_ok", inst_data_ok, 32'(expect_ok && id == 4'd0));
        chk("resp_data_data_ok", data_data_ok, 32'(expect_ok && id == 4'd1));
        tick();
        rvalid = 1'b0;
    endtask

    // Scoreboard: compare every AR handshake and every routed R beat
    always @(negedge aclk) begin
        if (!reset) begin
            if (arvalid && arready) begin
                if (ar_q.size() == 0) begin
                    chk("ar_unexpected_arvalid", arvalid, 0);
                end else begin
                    mon_ar = ar_q.pop_front();
                    chk("ar_id", arid, mon_ar.id);
                    chk("ar_addr", araddr, mon_ar.addr);
                    chk("ar_size", arsize, mon_ar.size);
                end
            end
            if (inst_data_ok) begin
                if (inst_q.size() == 0) begin
                    chk("unexpected_inst_data_ok", inst_data_ok, 0);
                end else begin
                    mon_d = inst_q.pop_front();
                    chk("inst_rdata", inst_rdata, mon_d);
                end
            end
            if (data_data_ok) begin
                if (data_q.size() == 0) begin
                    chk("unexpected_data_data_ok", data_data_ok, 0);
                end else begin
                    mon_d = data_q.pop_front();
                    chk("data_rdata", data_rdata, mon_d);
                end
            end
        end
    end

    // Hard time limit so a broken design cannot hang the run
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        inst_req = 1'b0; inst_addr = '0; inst_size = '0;
        data_req = 1'b0; data_addr = '0; data_size = '0;
        wr_pend = 1'b0; wr_pend_addr = '0;
        arready = 1'b1; rvalid = 1'b0; rid = '0; rdata = '0;

        // Reset state, with requests and a response present during reset
        tick(); tick();
        inst_req = 1'b1; rvalid = 1'b1;
        probe();
        chk("rst_rready", rready, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_arid", arid, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arsize", arsize, 0);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_inst_data_ok", inst_data_ok, 0);
        inst_req = 1'b0; rvalid = 1'b0;
        reset = 1'b0;
        tick();
        probe();
        chk("post_rst_rready", rready, 1);
        chk("post_rst_arvalid", arvalid, 0);
        tick();

        // T1: single fetch, AR then R
        inst_req = 1'b1; inst_addr = 32'h1c000000; inst_size = 2'd2;
        probe();
        chk("t1_inst_addr_ok", inst_addr_ok, 1);
        chk("t1_data_addr_ok", data_addr_ok, 0);
        ar_q.push_back({4'd0, 32'h1c000000, 3'd2});
        tick();
        inst_req = 1'b0;
        probe();
        chk("t1_arvalid", arvalid, 1);
        chk("t1_arid", arid, 0);
        tick();
        respond(4'd0, 32'h02800000, 1'b1);

        // T2: both requesting, data wins first tie, then alternation D,I,D,I
        inst_req = 1'b1; inst_addr = 32'h1c000100; inst_size = 2'd2;
        data_req = 1'b1; data_addr = 32'h1c008000; data_size = 2'd2;
        ar_q.push_back({4'd1, 32'h1c008000, 3'd2});
        ar_q.push_back({4'd0, 32'h1c000100, 3'd2});
        ar_q.push_back({4'd1, 32'h1c008000, 3'd2});
        ar_q.push_back({4'd0, 32'h1c000100, 3'd2});
        for (int i = 0; i < 8; i++) begin
            probe();
            chk("t2_data_addr_ok", data_addr_ok, 32'(i % 4 == 0));
            chk("t2_inst_addr_ok", inst_addr_ok, 32'(i % 4 == 2));
            tick();
        end
        probe();
        chk("t2_full_inst", inst_addr_ok, 0);
        chk("t2_full_data", data_addr_ok, 0);
        tick();
        inst_req = 1'b0; data_req = 1'b0;
        respond(4'd1, 32'hd0000001, 1'b1);
        respond(4'd0, 32'ha0000001, 1'b1);
        respond(4'd1, 32'hd0000002, 1'b1);
        respond(4'd0, 32'ha0000002, 1'b1);

        // T3: load held by same-word pending store; fetch proceeds
        inst_req = 1'b1; inst_addr = 32'h1c000200; inst_size = 2'd2;
        data_req = 1'b1; data_addr = 32'h1c008004; data_size = 2'd2;
        wr_pend = 1'b1; wr_pend_addr = 32'h1c008006;
        probe();
        chk("t3_inst_addr_ok", inst_addr_ok, 1);
        chk("t3_data_blocked0", data_addr_ok, 0);
        ar_q.push_back({4'd0, 32'h1c000200, 3'd2});
        tick();
        inst_req = 1'b0;
        probe();
        chk("t3_data_blocked1", data_addr_ok, 0);
        tick();
        probe();
        chk("t3_data_blocked2", data_addr_ok, 0);
        tick();
        wr_pend = 1'b0;
        probe();
        chk("t3_data_addr_ok", data_addr_ok, 1);
        ar_q.push_back({4'd1, 32'h1c008004, 3'd2});
        tick();
        data_req = 1'b0;
        probe();
        chk("t3_arid", arid, 1);
        tick();
        respond(4'd0, 32'ha0000003, 1'b1);
        respond(4'd1, 32'hd0000003, 1'b1);

        // T4: third fetch stalls on the outstanding limit until a response
        inst_req = 1'b1; inst_addr = 32'h1c000400; inst_size = 2'd2;
        for (int i = 0; i < 6; i++) begin
            probe();
            chk("t4_inst_addr_ok", inst_addr_ok, 32'(i == 0 || i == 2));
            if (i == 0 || i == 2) ar_q.push_back({4'd0, 32'h1c000400, 3'd2});
            tick();
        end
        rvalid = 1'b1; rid = 4'd0; rdata = 32'ha0000004;
        inst_q.push_back(32'ha0000004);
        probe();
        chk("t4_full_addr_ok", inst_addr_ok, 0);
        chk("t4_rsp_data_ok", inst_data_ok, 1);
        tick();
        rvalid = 1'b0;
        probe();
        chk("t4_third_addr_ok", inst_addr_ok, 1);
        ar_q.push_back({4'd0, 32'h1c000400, 3'd2});
        tick();
        inst_req = 1'b0;
        probe();
        tick();
        respond(4'd0, 32'ha0000005, 1'b1);
        respond(4'd0, 32'ha0000006, 1'b1);

        // T5: AR held stable while arready is low
        arready = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h1c000300; inst_size = 2'd1;
        probe();
        chk("t5_inst_addr_ok", inst_addr_ok, 1);
        ar_q.push_back({4'd0, 32'h1c000300, 3'd1});
        tick();
        data_req = 1'b1; data_addr = 32'h1c008100; data_size = 2'd2;
        for (int i = 0; i < 5; i++) begin
            probe();
            chk("t5_arvalid", arvalid, 1);
            chk("t5_araddr", araddr, 32'h1c000300);
            chk("t5_arid", arid, 0);
            chk("t5_arsize", arsize, 1);
            chk("t5_no_inst_ok", inst_addr_ok, 0);
            chk("t5_no_data_ok", data_addr_ok, 0);
            tick();
        end
        arready = 1'b1; inst_req = 1'b0; data_req = 1'b0;
        probe();
        tick();
        respond(4'd0, 32'ha0000007, 1'b1);

        // T6a: responses with zero counter or unknown rid are dropped
        respond(4'd1, 32'hdead0001, 1'b0);
        respond(4'd5, 32'hdead0002, 1'b0);

        // T6b: grant and response of the same ID in one cycle keep the count
        inst_req = 1'b1; inst_addr = 32'h1c000500; inst_size = 2'd2;
        probe();
        chk("t6_grant0", inst_addr_ok, 1);
        ar_q.push_back({4'd0, 32'h1c000500, 3'd2});
        tick();
        probe();
        tick();
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h11112222;
        inst_q.push_back(32'h11112222);
        probe();
        chk("t6_grant1", inst_addr_ok, 1);
        chk("t6_same_cycle_data_ok", inst_data_ok, 1);
        ar_q.push_back({4'd0, 32'h1c000500, 3'd2});
        tick();
        rvalid = 1'b0;
        probe();
        tick();
        probe();
        chk("t6_grant2", inst_addr_ok, 1);
        ar_q.push_back({4'd0, 32'h1c000500, 3'd2});
        tick();
        probe();
        tick();
        probe();
        chk("t6_full_after", inst_addr_ok, 0);
        tick();
        inst_req = 1'b0;
        respond(4'd0, 32'ha0000008, 1'b1);
        respond(4'd0, 32'ha0000009, 1'b1);

        // T6c: reset while an AR is waiting for arready
        arready = 1'b0;
        data_req = 1'b1; data_addr = 32'h1c008200; data_size = 2'd2;
        probe();
        chk("t6c_data_addr_ok", data_addr_ok, 1);
        tick();
        data_req = 1'b0;
        probe();
        chk("t6c_arvalid_pre", arvalid, 1);
        reset = 1'b1;
        tick();
        probe();
        chk("t6c_arvalid_rst", arvalid, 0);
        chk("t6c_araddr_rst", araddr, 0);
        chk("t6c_rready_rst", rready, 0);
        reset = 1'b0;
        tick();
        arready = 1'b1;
        respond(4'd1, 32'hdead0003, 1'b0);

        chk("ar_q_drained", 32'(ar_q.size()), 0);
        chk("inst_q_drained", 32'(inst_q.size()), 0);
        chk("data_q_drained", 32'(data_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
